// File: rtl/nx_fifo_rd_stage.sv
// Read-side stage: issues credit-limited reads to the FIFO controller and buffers RAM data in a skid buffer.
// Optional stall counter enabled with NX_FIFO_RD_STAGE_PERF_EN.
module nx_fifo_rd_stage #(
  parameter int WIDTH      = 32,
  parameter int RD_LATENCY = 1,
  localparam int BUF_DEPTH = RD_LATENCY + 1,
  localparam int USED_W    = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              fifo_empty,
  output logic              fifo_ren,
  input  logic [WIDTH-1:0]  ram_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [USED_W-1:0] buf_used,
  output logic              overrun_err
`ifdef NX_FIFO_RD_STAGE_PERF_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = USED_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(BUF_DEPTH);
  localparam logic [USED_W-1:0] FULL_C   = USED_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(BUF_DEPTH - 1);

  logic [RD_LATENCY-1:0] sr_reg;
  logic [RD_LATENCY-1:0] sr_next;
  logic [PTR_W-1:0]      head_reg;
  logic [PTR_W-1:0]      tail_reg;
  logic [USED_W-1:0]     used_reg;
  logic [USED_W-1:0]     used_next;
  logic [WIDTH-1:0]      mem_reg [BUF_DEPTH];
  logic [BUF_DEPTH-1:0]  wr_sel;
  logic                  overrun_reg;
  logic                  pop;
  logic                  arrive;
  logic                  full;
  logic                  write_en;
  logic                  overrun_hit;
  logic [CNT_W-1:0]      inflight;
  logic [CNT_W-1:0]      committed;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CNT_W'(sr_reg[i]);
    end
  end

  assign out_valid   = (used_reg != '0);
  assign pop         = out_valid & out_ready;
  assign arrive      = sr_reg[RD_LATENCY-1];
  assign full        = (used_reg == FULL_C);
  assign write_en    = arrive & ~clear & (~full | pop);
  assign overrun_hit = arrive & ~clear & full & ~pop;

  // Credit counts buffered plus in-flight words; a same-cycle pop frees a slot,
  // so out_ready reaches fifo_ren combinationally.
  assign committed = CNT_W'(used_reg) + inflight - CNT_W'(pop);
  assign fifo_ren  = rst_n & ~fifo_empty & ~clear & (committed < DEPTH_C);

  generate
    if (RD_LATENCY == 1) begin : g_sr1
      assign sr_next = fifo_ren;
    end else begin : g_srn
      assign sr_next = {sr_reg[RD_LATENCY-2:0], fifo_ren};
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_wr_sel
      assign wr_sel[gi] = write_en & (tail_reg == PTR_W'(gi));
    end
  endgenerate

  always_comb begin
    used_next = used_reg;
    unique case ({write_en, pop})
      2'b10:   used_next = used_reg + 1'b1;
      2'b01:   used_next = used_reg - 1'b1;
      default: used_next = used_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_reg      <= '0;
      head_reg    <= '0;
      tail_reg    <= '0;
      used_reg    <= '0;
      overrun_reg <= 1'b0;
    end else if (clear) begin
      sr_reg      <= '0;
      head_reg    <= '0;
      tail_reg    <= '0;
      used_reg    <= '0;
      overrun_reg <= 1'b0;
    end else begin
      sr_reg   <= sr_next;
      used_reg <= used_next;
      if (write_en) begin
        tail_reg <= ptr_inc(tail_reg);
      end
      if (pop) begin
        head_reg <= ptr_inc(head_reg);
      end
      if (overrun_hit) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  // Storage is not flushed by clear; only occupancy tracking is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (wr_sel[i]) begin
          mem_reg[i] <= ram_rd_data;
        end
      end
    end
  end

  assign out_data    = mem_reg[head_reg];
  assign buf_used    = used_reg;
  assign overrun_err = overrun_reg;

`ifdef NX_FIFO_RD_STAGE_PERF_EN
  logic [15:0] stall_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_reg <= '0;
    end else if (clear) begin
      stall_reg <= '0;
    end else if (out_valid && !out_ready && (stall_reg != 16'hFFFF)) begin
      stall_reg <= stall_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_reg;
`endif

endmodule

// File: tb/tb_nx_fifo_rd_stage.sv
// Randomized bench for nx_fifo_rd_stage: one instance per legal RD_LATENCY, each fed by a
// behavioural FIFO controller and checked against an issue-order scoreboard.
module tb_nx_fifo_rd_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  clear;
  logic [1:0]  fifo_empty;
  logic [1:0]  fifo_ren;
  logic [1:0]  out_valid;
  logic [1:0]  out_ready;
  logic [1:0]  overrun_err;
  logic [31:0] ram_rd_data [2];
  logic [31:0] out_data [2];
  logic [1:0]  buf_used [2];
`ifdef NX_FIFO_RD_STAGE_PERF_EN
  logic [15:0] stall_cnt [2];
`endif

  nx_fifo_rd_stage #(.WIDTH(32), .RD_LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .clear(clear[0]), .fifo_empty(fifo_empty[0]),
    .fifo_ren(fifo_ren[0]), .ram_rd_data(ram_rd_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .buf_used(buf_used[0]),
    .overrun_err(overrun_err[0])
`ifdef NX_FIFO_RD_STAGE_PERF_EN
    , .stall_cnt(stall_cnt[0])
`endif
  );

  nx_fifo_rd_stage #(.WIDTH(32), .RD_LATENCY(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .clear(clear[1]), .fifo_empty(fifo_empty[1]),
    .fifo_ren(fifo_ren[1]), .ram_rd_data(ram_rd_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .buf_used(buf_used[1]),
    .overrun_err(overrun_err[1])
`ifdef NX_FIFO_RD_STAGE_PERF_EN
    , .stall_cnt(stall_cnt[1])
`endif
  );

  // Environment and reference state
  int          lat [2];
  logic [31:0] ctrl_mem [2][512];
  int          ctrl_rd [2];
  int          ctrl_wr [2];
  logic [31:0] iss_word [2][1024];
  int          iss_cyc [2][1024];
  int          iss_wr [2];
  int          pop_idx [2];
  logic [31:0] rd_bus [2][4096];
  int          stall_m [2];
  int          last_buffered [2];
  logic [1:0]  rdy_cfg;
  logic [1:0]  clr_cfg;
  logic        rst_cfg;
  int          cyc;
  int          n_cmp;
  int          n_err;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Words whose read was issued more than RD_LATENCY cycles ago and not yet consumed.
  function automatic int model_buffered(input int d);
    int n = 0;
    for (int k = pop_idx[d]; k < iss_wr[d]; k++) begin
      if (iss_cyc[d][k] + lat[d] < cyc) n++;
    end
    return n;
  endfunction

  function automatic void model_flush(input int d);
    pop_idx[d] = iss_wr[d];
    ctrl_rd[d] = ctrl_wr[d];
    stall_m[d] = 0;
  endfunction

  task automatic push(input int d, input int count);
    for (int i = 0; i < count; i++) begin
      ctrl_mem[d][ctrl_wr[d]] = $urandom;
      ctrl_wr[d]++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (cyc >= 4000) begin
      $display("FAIL cycle_budget: got %0d expected below 4000", cyc);
      $fatal(1);
    end
    rst_n     = rst_cfg;
    out_ready = rdy_cfg;
    clear     = clr_cfg;
    for (int d = 0; d < 2; d++) begin
      fifo_empty[d]  = (ctrl_rd[d] == ctrl_wr[d]);
      rd_bus[d][cyc] = $urandom;
      ram_rd_data[d] = (cyc >= lat[d]) ? rd_bus[d][cyc - lat[d]] : 32'h0;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      int   buffered;
      int   outst;
      logic exp_valid;
      logic exp_pop;
      logic exp_ren;
      buffered  = model_buffered(d);
      outst     = iss_wr[d] - pop_idx[d];
      exp_valid = (buffered > 0);
      exp_pop   = exp_valid && out_ready[d];
      exp_ren   = rst_n && !fifo_empty[d] && !clear[d] && ((outst - int'(exp_pop)) < lat[d] + 1);
      last_buffered[d] = buffered;
      check_val($sformatf("d%0d out_valid", d), 32'(out_valid[d]), 32'(exp_valid));
      check_val($sformatf("d%0d buf_used", d), 32'(buf_used[d]), buffered);
      check_val($sformatf("d%0d fifo_ren", d), 32'(fifo_ren[d]), 32'(exp_ren));
      check_val($sformatf("d%0d overrun_err", d), 32'(overrun_err[d]), 32'h0);
      if (!rst_n) check_val($sformatf("d%0d out_data_rst", d), out_data[d], 32'h0);
      else if (exp_valid) check_val($sformatf("d%0d out_data", d), out_data[d], iss_word[d][pop_idx[d]]);
`ifdef NX_FIFO_RD_STAGE_PERF_EN
      check_val($sformatf("d%0d stall_cnt", d), 32'(stall_cnt[d]), stall_m[d]);
`endif
      if (!rst_n || clear[d]) begin
        model_flush(d);
      end else begin
        if (exp_pop) begin
          $display("pop d%0d cycle %0d data %08h", d, cyc, iss_word[d][pop_idx[d]]);
          pop_idx[d]++;
        end
        if (exp_valid && !out_ready[d] && stall_m[d] < 16'hFFFF) stall_m[d]++;
        if (fifo_ren[d] && ctrl_rd[d] != ctrl_wr[d]) begin
          rd_bus[d][cyc]          = ctrl_mem[d][ctrl_rd[d]];
          iss_word[d][iss_wr[d]]  = ctrl_mem[d][ctrl_rd[d]];
          iss_cyc[d][iss_wr[d]]   = cyc;
          iss_wr[d]++;
          ctrl_rd[d]++;
        end
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    lat[0] = 1;
    lat[1] = 2;
    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    for (int d = 0; d < 2; d++) begin
      ctrl_rd[d] = 0; ctrl_wr[d] = 0; iss_wr[d] = 0; pop_idx[d] = 0;
      stall_m[d] = 0; last_buffered[d] = 0;
      ram_rd_data[d] = 32'h0;
    end
    rst_n = 1'b0; rst_cfg = 1'b0;
    rdy_cfg = 2'b11; clr_cfg = 2'b00;
    out_ready = 2'b11; clear = 2'b00; fifo_empty = 2'b11;

    // Reset values, then release
    push(0, 2);
    push(1, 2);
    run(3);
    rst_cfg = 1'b1;
    run(8);

    // Streaming, 4 words at RD_LATENCY=1
    push(0, 4);
    run(8);

    // Backpressure, 4 words at RD_LATENCY=2
    rdy_cfg = 2'b01;
    push(1, 4);
    run(10);
    rdy_cfg = 2'b11;
    run(8);

    // Single-cycle ready pulses on both instances
    push(0, 8);
    push(1, 8);
    for (int i = 0; i < 30; i++) begin
      rdy_cfg = (i % 2 == 0) ? 2'b11 : 2'b00;
      tick();
    end
    rdy_cfg = 2'b11;
    run(6);

    // Clear coincident with the first arrival, second read still in flight
    rdy_cfg = 2'b00;
    push(1, 2);
    run(2);
    clr_cfg = 2'b10;
    tick();
    clr_cfg = 2'b00;
    run(3);
    rdy_cfg = 2'b11;
    push(1, 3);
    run(8);

    // Wrap-around under random ready
    push(0, 12);
    push(1, 12);
    for (int i = 0; i < 70; i++) begin
      rdy_cfg = 2'($urandom_range(0, 3));
      tick();
    end
    rdy_cfg = 2'b11;
    run(8);

    // Asynchronous reset mid-stream with two words buffered
    rdy_cfg = 2'b00;
    push(1, 4);
    for (int i = 0; i < 20 && last_buffered[1] != 2; i++) tick();
    check_val("d1 pre_reset_buffered", 32'(last_buffered[1]), 32'd2);
    rst_cfg = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check_val($sformatf("d%0d async out_valid", d), 32'(out_valid[d]), 32'h0);
      check_val($sformatf("d%0d async buf_used", d), 32'(buf_used[d]), 32'h0);
      check_val($sformatf("d%0d async out_data", d), out_data[d], 32'h0);
      check_val($sformatf("d%0d async fifo_ren", d), 32'(fifo_ren[d]), 32'h0);
      model_flush(d);
    end
    run(2);
    rst_cfg = 1'b1;
    rdy_cfg = 2'b11;
    run(5);
    push(1, 3);
    push(0, 3);
    run(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
